// File: rtl/pb_debounce_onepulse_if.sv
// Push-button signal bundle between the raw button source and the debounce/one-pulse conditioner.
// The master drives the raw level; the slave returns the conditioned level and strobes.
interface pb_debounce_onepulse_if;
  logic pb_in;
  logic pb_debounced;
  logic pb_press;
  logic pb_release;
  logic pb_toggle;

  modport master (
    output pb_in,
    input  pb_debounced,
    input  pb_press,
    input  pb_release,
    input  pb_toggle
  );

  modport slave (
    input  pb_in,
    output pb_debounced,
    output pb_press,
    output pb_release,
    output pb_toggle
  );
endinterface

// File: rtl/pb_debounce_onepulse.sv
// Push-button conditioner: two-flop synchroniser, counter-qualified debounce FSM,
// registered press/release strobes and a press-toggled latch.
module pb_debounce_onepulse #(
  parameter int CNT_WIDTH       = 20,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic                   clk,
  input logic                   rst,
  pb_debounce_onepulse_if.slave pb
);

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HI,
    S_HIGH,
    S_WAIT_LO
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s1, s2;
  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 deb_q, deb_nxt;
  logic                 press_q, press_nxt;
  logic                 release_q, release_nxt;
  logic                 toggle_q, toggle_nxt;
  logic                 qual_hi, qual_lo;

  // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pb.pb_in;
      s2 <= s1;
    end
  end

  // Reaching the last count while still at the new level accepts the transition.
  assign qual_hi = (state == S_WAIT_HI) && s2  && (cnt == CNT_LAST);
  assign qual_lo = (state == S_WAIT_LO) && !s2 && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOW;
      cnt       <= '0;
      deb_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      deb_q     <= deb_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
      toggle_q  <= toggle_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    unique case (state)
      S_LOW: begin
        if (s2) begin
          state_nxt = S_WAIT_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_WAIT_HI: begin
        if (!s2)          state_nxt = S_LOW;
        else if (qual_hi) state_nxt = S_HIGH;
        else              cnt_nxt   = cnt + CNT_ONE;
      end
      S_HIGH: begin
        if (!s2) begin
          state_nxt = S_WAIT_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_WAIT_LO: begin
        if (s2)           state_nxt = S_HIGH;
        else if (qual_lo) state_nxt = S_LOW;
        else              cnt_nxt   = cnt + CNT_ONE;
      end
      default: state_nxt = S_LOW;
    endcase
  end

  // Strobes are computed from the accepting transition so they coincide with the level change.
  always_comb begin
    deb_nxt     = deb_q;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    toggle_nxt  = toggle_q;
    if (qual_hi) begin
      deb_nxt    = 1'b1;
      press_nxt  = 1'b1;
      toggle_nxt = !toggle_q;
    end else if (qual_lo) begin
      deb_nxt     = 1'b0;
      release_nxt = 1'b1;
    end
  end

  assign pb.pb_debounced = deb_q;
  assign pb.pb_press     = press_q;
  assign pb.pb_release   = release_q;
  assign pb.pb_toggle    = toggle_q;

endmodule

// File: tb/tb_pb_debounce_onepulse.sv
// Bench for pb_debounce_onepulse with DEBOUNCE_CYCLES=4: directed button patterns push the
// expected strobes (edge number, kind, toggle) into a scoreboard popped by a strobe monitor.
module tb_pb_debounce_onepulse;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam int LAT = D + 2;

  typedef struct {
    bit is_press;
    int edge_no;
    bit toggle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pb_debounce_onepulse_if bus ();

  pb_debounce_onepulse #(.CNT_WIDTH(CW), .DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .pb  (bus.slave)
  );

  always #5 clk = ~clk;

  int   edge_cnt = 0;
  int   passed   = 0;
  int   total    = 0;
  exp_t sb[$];
  bit   exp_toggle = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edge_cnt);
  endtask

  // Called at a negedge right after pb_in takes its new settled level.
  task automatic push_press();
    exp_toggle = !exp_toggle;
    sb.push_back('{1'b1, edge_cnt + LAT, exp_toggle});
  endtask

  task automatic push_release();
    sb.push_back('{1'b0, edge_cnt + LAT, exp_toggle});
  endtask

  task automatic set_pb(input bit v);
    @(negedge clk);
    bus.pb_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_levels(input string name, input bit deb);
    check({name, "_debounced"}, int'(bus.pb_debounced), int'(deb));
    check({name, "_toggle"}, int'(bus.pb_toggle), int'(exp_toggle));
  endtask

  task automatic check_reset_zero();
    check("reset_outputs",
          int'({bus.pb_debounced, bus.pb_press, bus.pb_release, bus.pb_toggle}), 0);
  endtask

  // Strobe monitor: each strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (bus.pb_press || bus.pb_release) begin
      check("strobe_exclusive", int'(bus.pb_press && bus.pb_release), 0);
      check("strobe_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind", int'(bus.pb_press), int'(e.is_press));
        check("strobe_edge", edge_cnt, e.edge_no);
        check("strobe_toggle", int'(bus.pb_toggle), int'(e.toggle));
        check("strobe_level", int'(bus.pb_debounced), int'(e.is_press));
      end
    end
  end

  initial begin
    bus.pb_in = 1'b1;

    // Reset held 3 edges with button high; qualification starts at release.
    repeat (3) begin
      @(negedge clk);
      check_reset_zero();
    end
    rst = 1'b0;
    exp_toggle = 1'b0;
    push_press();
    idle(LAT - 1);
    check("latency_not_early", int'(bus.pb_debounced), 0);
    idle(5);
    check_levels("after_reset_press", 1'b1);

    // Clean release, then a clean press/release held 10 cycles.
    set_pb(1'b0); push_release(); idle(10);
    check_levels("release1", 1'b0);
    set_pb(1'b1); push_press(); idle(10);
    check_levels("press2", 1'b1);
    set_pb(1'b0); push_release(); idle(10);
    check_levels("release2", 1'b0);

    // Bounce rejection: no high run reaches D cycles.
    set_pb(1'b1); set_pb(1'b1); set_pb(1'b1); set_pb(1'b0);
    set_pb(1'b1); set_pb(1'b1); set_pb(1'b0);
    idle(12);
    check_levels("bounce_reject", 1'b0);

    // Bounce then settle high: latency counts from the final steady run.
    set_pb(1'b1); set_pb(1'b0); set_pb(1'b1); set_pb(1'b1); set_pb(1'b0);
    set_pb(1'b1); push_press(); idle(10);
    check_levels("bounce_settle", 1'b1);
    set_pb(1'b0); push_release(); idle(10);
    check_levels("bounce_settle_rel", 1'b0);

    // Plain reset so the toggle sequence starts from 0.
    @(negedge clk); rst = 1'b1; exp_toggle = 1'b0;
    @(negedge clk); check_reset_zero();
    rst = 1'b0;
    idle(3);

    // Three press/release cycles: toggle goes 1,0,1 and release leaves it alone.
    for (int i = 0; i < 3; i++) begin
      set_pb(1'b1); push_press(); idle(9);
      check_levels("toggle_press", 1'b1);
      set_pb(1'b0); push_release(); idle(9);
      check_levels("toggle_release", 1'b0);
    end
    check("toggle_final", int'(bus.pb_toggle), 1);

    // Reset on the 4th sampling edge abandons the count; fresh qualification afterwards.
    set_pb(1'b1);
    idle(3);
    rst = 1'b1;
    exp_toggle = 1'b0;
    @(negedge clk); check_reset_zero();
    @(negedge clk); check_reset_zero();
    rst = 1'b0;
    push_press();
    idle(LAT - 1);
    check("midreset_not_early", int'(bus.pb_debounced), 0);
    idle(5);
    check_levels("midreset_press", 1'b1);

    idle(4);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
